// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target port.
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Wide enough for any practical DATA_WIDTH; users slice the low bits.
    localparam int FILL_MAX_W = 256;
    localparam logic [FILL_MAX_W-1:0] UNDERRUN_FILL = '1;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer with rise/fall pulses taken from the last two synchronized samples.
module spi_target_sync
    import spi_target_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = sr[STAGES-1] & ~prev;
    assign fall = ~sr[STAGES-1] & prev;

endmodule

// File: rtl/spi_target_port.sv
// SPI target (slave) port, all four modes, MSB first, variable word length.
// Optional sticky overrun/underrun flags are built when SPI_TARGET_STATUS_EN is defined.
module spi_target_port
    import spi_target_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic [$clog2(DATA_WIDTH)-1:0] word_bits,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          miso_oe,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic                          underrun,
    input  logic                          status_clr,
    output logic                          busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic mosi_s;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) mosi_sr <= '0;
        else       mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_s, cs_rise, cs_fall};

    logic lead, trail, sample_edge, shift_edge, deselect;
    assign lead        = cpol ? sclk_fall : sclk_rise;
    assign trail       = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead  : trail;
    assign deselect    = cs_s | ~enable;

    state_t state, state_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, hold_data, rx_mask;
    logic                  hold_full, miso_q, done_q, word_done;
    logic                  overrun_set, underrun_set;

    assign word_done = (state == SHIFT) && !deselect && sample_edge && (bit_cnt == word_bits);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (word_done) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (deselect) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= word_done;
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
            case (state)
                LOAD: begin
                    bit_cnt <= '0;
                    miso_q  <= 1'b0;
                    if (hold_full) begin
                        tx_sr     <= hold_data;
                        hold_full <= 1'b0;
                    end else begin
                        tx_sr <= UNDERRUN_FILL[DATA_WIDTH-1:0];
                    end
                end
                SHIFT: if (!deselect) begin
                    if (sample_edge) begin
                        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // In cpha=0 the trailing edge that closes the previous word lands
                    // after the reload; bit_cnt==0 marks it so the MSB is not lost.
                    if (shift_edge && (cpha || bit_cnt != '0)) begin
                        miso_q <= tx_sr[word_bits];
                        tx_sr  <= tx_sr << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_mask = ~((ONES << word_bits) << 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (done_q) begin
            rx_data  <= rx_sr & rx_mask;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign tx_ready     = ~hold_full;
    assign busy         = (state != IDLE);
    assign miso_oe      = busy;
    assign miso         = miso_oe & (cpha ? miso_q : tx_sr[word_bits]);
    assign overrun_set  = done_q && rx_valid && !rx_ready;
    assign underrun_set = (state == LOAD) && !hold_full;

`ifdef SPI_TARGET_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (overrun_set)     overrun <= 1'b1;
            else if (status_clr) overrun <= 1'b0;
            if (underrun_set)     underrun <= 1'b1;
            else if (status_clr)  underrun <= 1'b0;
        end
    end
`else
    assign overrun  = 1'b0;
    assign underrun = 1'b0;
    logic unused_status;
    assign unused_status = &{1'b0, status_clr, overrun_set, underrun_set};
`endif

endmodule

// File: tb/tb_spi_target_port.sv
// Self-checking bench for spi_target_port: directed scenarios plus randomized transfers vs a stream model.
module tb_spi_target_port;

    localparam int DW   = 32;
    localparam int HALF = 6;

`ifdef SPI_TARGET_STATUS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, cpol, cpha;
    logic [4:0]    word_bits;
    logic          sclk, cs_n, mosi;
    logic          miso, miso_oe;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic          overrun, underrun, status_clr, busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] rx_got[$];

    spi_target_port #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cpol(cpol), .cpha(cpha),
        .word_bits(word_bits), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .underrun(underrun), .status_clr(status_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && rx_valid && rx_ready) rx_got.push_back(rx_data);

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mask64(input int wb);
        return (64'd1 << (wb + 1)) - 64'd1;
    endfunction

    // Model: the initiator sees the tx words (or all ones when nothing was queued) back to back.
    function automatic logic [63:0] exp_miso(input int nw, input int wb,
                                             input logic [31:0] txw [2], input bit have_tx);
        logic [63:0] s = '0;
        for (int w = 0; w < nw; w++)
            s = (s << (wb + 1)) | ((have_tx ? {32'd0, txw[w]} : 64'hFFFF_FFFF_FFFF_FFFF) & mask64(wb));
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input int wb);
        cpol = pol; cpha = pha; word_bits = 5'(wb); sclk = pol;
        idle(6);
    endtask

    task automatic clear_flags();
        status_clr = 1'b1; idle(1); status_clr = 1'b0; idle(1);
    endtask

    task automatic push_tx(input logic [31:0] w);
        int t = 0;
        while (!tx_ready && t < 500) begin idle(1); t++; end
        if (t >= 500) begin
            tests++; fails++;
            $display("FAIL push_tx timeout: tx_ready=%b required 1", tx_ready);
        end else begin
            tx_data = w; tx_valid = 1'b1; idle(1); tx_valid = 1'b0;
        end
    endtask

    // Initiator: clocks n bits MSB first, returns what it sampled on miso.
    task automatic spi_bits(input int n, input logic [63:0] mo, output logic [63:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi = mo[n-1-i];
                idle(HALF);
                mi[n-1-i] = miso;
                sclk = ~cpol;
                idle(HALF);
                sclk = cpol;
            end else begin
                idle(HALF);
                sclk = ~cpol;
                mosi = mo[n-1-i];
                idle(HALF);
                mi[n-1-i] = miso;
                sclk = cpol;
            end
        end
    endtask

    task automatic run_words(input int nw, input int wb, input logic [31:0] txw [2],
                             input logic [31:0] rxw [2], input bit have_tx, output logic [63:0] mi);
        logic [63:0] mo = '0;
        for (int w = 0; w < nw; w++) mo = (mo << (wb + 1)) | ({32'd0, rxw[w]} & mask64(wb));
        if (have_tx) push_tx(txw[0]);
        cs_n = 1'b0;
        idle(4);
        fork
            begin if (have_tx && nw > 1) push_tx(txw[1]); end
            spi_bits(nw * (wb + 1), mo, mi);
        join
        idle(HALF);
        cs_n = 1'b1;
        idle(HALF + 4);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; word_bits = 5'd7;
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
        rx_ready = 1'b1; status_clr = 1'b0;
        idle(3);
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (rx_data !== 32'd0) begin fails++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
        tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_mode0_basic();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        t[0] = 32'hA5; t[1] = '0; r[0] = 32'h3C; r[1] = '0;
        set_mode(1'b0, 1'b0, 7);
        rx_got.delete();
        run_words(1, 7, t, r, 1'b1, mi);
        tests++; if (mi !== 64'hA5) begin fails++; $display("FAIL mode0_miso: got %h want a5", mi); end
        tests++; if (rx_got.size() != 1) begin fails++; $display("FAIL mode0_rx_count: got %0d want 1", rx_got.size()); end
        else begin
            tests++; if (rx_got[0] !== 32'h3C) begin fails++; $display("FAIL mode0_rx_data: got %h want 3c", rx_got[0]); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mode0_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_mode3_back_to_back();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        t[0] = 32'h0F0F; t[1] = 32'hF0F0; r[0] = 32'h1234; r[1] = 32'hBEEF;
        set_mode(1'b1, 1'b1, 15);
        rx_got.delete();
        run_words(2, 15, t, r, 1'b1, mi);
        tests++; if (mi !== 64'h0F0F_F0F0) begin fails++; $display("FAIL mode3_miso: got %h want 0f0ff0f0", mi); end
        tests++; if (rx_got.size() != 2) begin fails++; $display("FAIL mode3_rx_count: got %0d want 2", rx_got.size()); end
        else begin
            tests++; if (rx_got[0] !== 32'h1234) begin fails++; $display("FAIL mode3_rx0: got %h want 1234", rx_got[0]); end
            tests++; if (rx_got[1] !== 32'hBEEF) begin fails++; $display("FAIL mode3_rx1: got %h want beef", rx_got[1]); end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        t[0] = '0; t[1] = '0; r[0] = $urandom; r[1] = '0;
        set_mode(1'b0, 1'b0, 7);
        clear_flags();
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_cleared_before: got %b want 0", underrun); end
        run_words(1, 7, t, r, 1'b0, mi);
        tests++; if (mi !== 64'hFF) begin fails++; $display("FAIL underrun_fill: got %h want ff", mi); end
        idle(5);
        tests++; if (underrun !== FLAGS_ON) begin fails++; $display("FAIL underrun_flag: got %b want %b", underrun, FLAGS_ON); end
        status_clr = 1'b1; idle(1); status_clr = 1'b0;
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_clr: got %b want 0", underrun); end
    endtask

    task automatic test_overrun();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        t[0] = $urandom_range(0, 255); t[1] = $urandom_range(0, 255); r[0] = 32'h11; r[1] = 32'h22;
        set_mode(1'b0, 1'b0, 7);
        clear_flags();
        rx_ready = 1'b0;
        run_words(2, 7, t, r, 1'b1, mi);
        tests++; if (mi !== exp_miso(2, 7, t, 1'b1)) begin fails++; $display("FAIL overrun_miso: got %h want %h", mi, exp_miso(2, 7, t, 1'b1)); end
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL overrun_rx_valid: got %b want 1", rx_valid); end
        tests++; if (rx_data !== 32'h22) begin fails++; $display("FAIL overrun_rx_data: got %h want 22", rx_data); end
        tests++; if (overrun !== FLAGS_ON) begin fails++; $display("FAIL overrun_flag: got %b want %b", overrun, FLAGS_ON); end
        rx_ready = 1'b1;
        idle(2);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL overrun_drain: got %b want 0", rx_valid); end
        clear_flags();
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr: got %b want 0", overrun); end
        rx_got.delete();
    endtask

    task automatic test_abort();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        set_mode(1'b0, 1'b0, 7);
        rx_got.delete();
        push_tx($urandom);
        cs_n = 1'b0;
        idle(4);
        spi_bits(5, {59'd0, 5'($urandom)}, mi);
        idle(HALF);
        cs_n = 1'b1;
        idle(12);
        tests++; if (rx_got.size() != 0) begin fails++; $display("FAIL abort_no_rx: got %0d words want 0", rx_got.size()); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL abort_tx_popped: got %b want 1", tx_ready); end
        t[0] = $urandom_range(0, 255); t[1] = '0; r[0] = 32'h81; r[1] = '0;
        run_words(1, 7, t, r, 1'b1, mi);
        tests++; if (mi !== {32'd0, t[0]}) begin fails++; $display("FAIL abort_next_miso: got %h want %h", mi, t[0]); end
        tests++; if (rx_got.size() != 1) begin fails++; $display("FAIL abort_next_count: got %0d want 1", rx_got.size()); end
        else begin
            tests++; if (rx_got[0] !== 32'h81) begin fails++; $display("FAIL abort_next_rx: got %h want 81", rx_got[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] t[2], r[2];
        logic [63:0] mi;
        set_mode(1'b0, 1'b1, 15);
        rx_got.delete();
        push_tx($urandom);
        cs_n = 1'b0;
        idle(4);
        spi_bits(6, {58'd0, 6'($urandom)}, mi);
        reset = 1'b1;
        idle(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_miso_oe: got %b want 0", miso_oe); end
        tests++; if (miso !== 1'b0) begin fails++; $display("FAIL rstmid_miso: got %b want 0", miso); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
        tests++; if (rx_data !== 32'd0) begin fails++; $display("FAIL rstmid_rx_data: got %h want 0", rx_data); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
        cs_n = 1'b1; sclk = cpol;
        idle(2);
        reset = 1'b0;
        idle(6);
        tests++; if (rx_got.size() != 0) begin fails++; $display("FAIL rstmid_no_rx: got %0d words want 0", rx_got.size()); end
        t[0] = $urandom_range(0, 65535); t[1] = '0; r[0] = $urandom_range(0, 65535); r[1] = '0;
        run_words(1, 15, t, r, 1'b1, mi);
        tests++; if (mi !== {32'd0, t[0]}) begin fails++; $display("FAIL rstmid_next_miso: got %h want %h", mi, t[0]); end
        tests++; if (rx_got.size() != 1) begin fails++; $display("FAIL rstmid_next_count: got %0d want 1", rx_got.size()); end
        else begin
            tests++; if (rx_got[0] !== r[0]) begin fails++; $display("FAIL rstmid_next_rx: got %h want %h", rx_got[0], r[0]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] t[2], r[2];
        logic [63:0] mi, em;
        int wb, nw;
        bit have_tx;
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: wb = 7;
                1: wb = 15;
                2: wb = 31;
                default: wb = $urandom_range(3, 30);
            endcase
            nw = $urandom_range(1, 2);
            have_tx = ($urandom_range(0, 3) != 0);
            t[0] = $urandom; t[1] = $urandom; r[0] = $urandom; r[1] = $urandom;
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wb);
            rx_got.delete();
            run_words(nw, wb, t, r, have_tx, mi);
            em = exp_miso(nw, wb, t, have_tx);
            tests++; if (mi !== em) begin fails++; $display("FAIL rand%0d_miso: got %h want %h (cpol=%b cpha=%b wb=%0d)", it, mi, em, cpol, cpha, wb); end
            tests++; if (rx_got.size() != nw) begin fails++; $display("FAIL rand%0d_rx_count: got %0d want %0d", it, rx_got.size(), nw); end
            else begin
                for (int w = 0; w < nw; w++) begin
                    tests++;
                    if ({32'd0, rx_got[w]} !== ({32'd0, r[w]} & mask64(wb))) begin
                        fails++;
                        $display("FAIL rand%0d_rx%0d: got %h want %h", it, w, rx_got[w], {32'd0, r[w]} & mask64(wb));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode3_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
